// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the one-hot round-robin arbiter.
//   state_t    - arbiter states (IDLE, GRANT)
//   DEF_N      - default number of request lines
//   DEF_TIMEOUT- default ack-wait limit in cycles
//   ptr_width  - rotating pointer width, never below one bit
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_N = 8;
  localparam int DEF_TIMEOUT = 16;
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   pend   in  N   pending request vector
//   ptr    in  PW  index where the search starts (wraps N-1 -> 0)
//   select out N   one-hot first pending bit at or after ptr, else zero
//   found  out 1   any request pending
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  select,
  output logic          found
);
  logic [N-1:0] hi, src;
  // Bits at or above ptr take priority; if none, fall back to the whole vector (the wrap).
  assign hi = pend & ~((N'(1) << ptr) - N'(1));
  assign src = |hi ? hi : pend;
  // Isolating the lowest set bit keeps the result strictly one-hot or zero.
  assign select = src & (~src + N'(1));
  assign found = |pend;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: captures request pulses and grants them round-robin, one-hot, held until ack.
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   req  in  N  request pulses/levels, accumulated into pend
//   ack  in  1  consumer took the current grant (only meaningful while en=1)
//   gnt  out N  registered one-hot grant, zero when en=0
//   en   out 1  registered grant valid
//   pend out N  registered pending-request vector
//   err  out 1  sticky ack-timeout flag
// Optional macro ARB_TIMEOUT_EN: retire a grant after TIMEOUT unacknowledged GRANT cycles and set err.
module onehot_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic         en,
  output logic [N-1:0] pend,
  output logic         err
);
  localparam int PW = ptr_width(N);
  if (N < 2 || TIMEOUT < 2) begin : g_bad_param
    $error("onehot_rr_arbiter needs N >= 2 and TIMEOUT >= 2");
  end
  state_t state_q;
  logic [N-1:0] pend_q, pend_d, gnt_q, select, clr;
  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic en_q, err_q, err_d, found, retire, tmo;
  rr_pick #(.N(N)) u_pick (
    .pend(pend_q),
    .ptr(ptr_q),
    .select(select),
    .found(found)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  // An ack on the timeout edge wins, so tmo only fires without one.
  assign tmo = state_q == GRANT && !ack && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= (state_q == GRANT && !retire) ? cnt_q + CW'(1) : '0;
  end
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    gidx = '0;
    for (int k = 0; k < N; k++) if (gnt_q[k]) gidx = PW'(k);
  end
  assign retire = state_q == GRANT && (ack || tmo);
  assign clr = retire ? gnt_q : '0;
  // req is OR-ed in after the clear so a same-edge request keeps its bit pending.
  assign pend_d = (pend_q & ~clr) | req;
  assign ptr_d = retire ? (gidx == PW'(N - 1) ? '0 : gidx + PW'(1)) : ptr_q;
  assign err_d = err_q | tmo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      en_q <= 1'b0;
      pend_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      if (state_q == IDLE && found) begin
        state_q <= GRANT;
        gnt_q <= select;
        en_q <= 1'b1;
      end else if (retire) begin
        state_q <= IDLE;
        gnt_q <= '0;
        en_q <= 1'b0;
      end
    end
  end
  assign gnt = gnt_q;
  assign en = en_q;
  assign pend = pend_q;
  assign err = err_q;
endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures request pulses on up to N lines and arbitrates among them round-robin.
- Presents exactly one registered one-hot grant plus a valid strobe, which drive the encoder's i and en inputs.
- Holds each grant until the downstream consumer acknowledges it. Guarantees the encoder never sees more than one hot bit.

Parameters:
- N, 8, number of request lines and width of the one-hot grant; N >= 2.
- TIMEOUT, 16, ack-wait limit in cycles; used only with ARB_TIMEOUT_EN; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request pulses/levels; a 1 sampled at a rising edge sets the matching pending bit.
- ack  input  1  consumer has taken the current grant; sampled only while en=1.
- gnt  output  N  registered one-hot grant (to encoder i); all-zero when en=0.
- en  output  1  registered grant valid (to encoder en).
- pend  output  N  registered pending-request vector.
- err  output  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset is asynchronous, active-high, one clock, as already decided.
- Reset values: gnt=0, en=0, pend=0, err=0, rotating pointer ptr=0, state=IDLE, timeout counter=0.
- Reset asserted mid-grant drops gnt/en immediately, with no wait for a clock edge.
- Pending capture every cycle: pend_next = (pend & ~clr_mask) | req.
  - clr_mask is the granted bit on an accepted ack (or a timeout), else 0.
  - req wins over clear on the same bit, so that bit stays pending.
- Selection is combinational from the registered pend.
  - Pick the first set bit searching from index ptr upward, wrapping N-1 -> 0.
  - The result is strictly one-hot or zero.
- State IDLE (en=0, gnt=0):
  - If pend != 0, register gnt = selected one-hot, en=1, go GRANT.
  - Else stay IDLE.
  - Latency: req high at edge t -> pend bit set after t -> gnt/en valid after t+1.
- State GRANT (en=1):
  - gnt is held stable. ack=0 -> remain.
  - ack=1 at an edge: clear that pend bit (subject to the req-wins rule), set ptr = (granted index + 1) mod N, set gnt=0 and en=0, go IDLE.
- Back-to-back grants are separated by one IDLE cycle with en=0. This is the intended behaviour and gives the encoder a clean boundary.
- ack while IDLE is ignored.
- req bits arriving during GRANT are accumulated in pend. They never alter the current gnt.
- All N requests pending with ptr=0 are served in order 0,1,...,N-1, then the pointer wraps to 0.
- Pointer width is $clog2(N). For non-power-of-two N, ptr wraps explicitly at N-1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A counter counts GRANT cycles without ack.
  - On reaching TIMEOUT, the grant is forcibly retired at that edge: pend bit cleared (req-wins rule still applies), ptr advanced, en/gnt cleared, state goes IDLE.
  - err is set and stays 1 until reset.
  - ack on the same edge as the timeout counts as a normal ack, with no err.
- Without the macro: no counter is synthesised, the grant is held indefinitely, and err is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - The state enum (IDLE, GRANT).
  - Default N and TIMEOUT constants.
  - The pointer-width function (clog2).
- Sub-module rr_pick (combinational): inputs pend[N] and ptr; outputs a one-hot select[N] and a found flag.
- The top instantiates rr_pick once and owns all registers.

Test Plan:
1. Reset:
   - Hold rst=1 with req=8'hFF -> gnt=0, en=0, pend=0.
   - Release rst, pulse req=8'b0000_0100 -> two edges later gnt=8'b0000_0100, en=1.
   - Hold until ack.
2. Round-robin order:
   - req=8'b0100_0101 for one cycle, ack every cycle while en=1.
   - Grants are 8'h01, 8'h04, 8'h40, each separated by one en=0 cycle; pend ends at 0.
3. Pointer fairness:
   - After serving bit 6 (ptr=7), pulse req=8'b1000_0001 -> grant 8'h80 first, then 8'h01 (wrap).
4. Same-cycle collision:
   - In GRANT on bit 2, assert ack and req=8'h04 on the same edge -> pend[2] stays 1 and bit 2 is re-granted after the wrap.
   - gnt is never two-hot.
5. Reset mid-operation:
   - Assert rst asynchronously between edges while en=1, gnt=8'h10 -> gnt/en drop before the next edge.
   - pend=0 afterwards.
6. ARB_TIMEOUT_EN, TIMEOUT=16:
   - Grant held with ack=0 -> at the 16th GRANT cycle en=0, err=1, pend bit cleared.
   - The next pending request is granted and err remains 1.
